// File: rtl/prog_loader.sv
// Boot-time program loader: unpacks a byte-stream frame into 13-bit instruction words for imem.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int WIDTH      = 13,
  parameter int IWIDTH     = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [WIDTH-1:0]      o_imem_data,
  output logic                  o_imem_we,
  output logic                  o_cpu_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [7:0]            o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t r_state, w_state_next, w_end_state;

  logic [7:0]              r_count;
  logic [7:0]              r_word_count;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [IWIDTH-1:0]       r_opcode;
  logic [WIDTH-IWIDTH-1:0] r_operand;
  logic                    w_too_many;
  logic                    w_hi_bad;

  // N is bounded here so the write address can never wrap.
  assign w_too_many = ({24'd0, i_byte_in} > (32'd1 << ADDR_WIDTH));
  assign w_hi_bad   = |i_byte_in[7:IWIDTH];

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  assign w_end_state = S_CHK;
`else
  assign w_end_state = S_DONE;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_byte_ready = 1'b0;
    o_imem_we    = 1'b0;
    o_cpu_hold   = 1'b1;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cpu_hold = 1'b0;
        if (i_start) w_state_next = S_COUNT;
      end
      S_DONE: begin
        o_cpu_hold = 1'b0;
        o_done     = 1'b1;
        if (i_start) w_state_next = S_COUNT;
      end
      S_ERR: begin
        o_err = 1'b1;
        if (i_start) w_state_next = S_COUNT;
      end
      S_COUNT: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (i_byte_valid) begin
          if (i_byte_in == 8'd0)  w_state_next = w_end_state;
          else if (w_too_many)    w_state_next = S_ERR;
          else                    w_state_next = S_HI;
        end
      end
      S_HI: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (i_byte_valid) w_state_next = w_hi_bad ? S_ERR : S_LO;
      end
      S_LO: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (i_byte_valid) w_state_next = S_WR;
      end
      S_WR: begin
        o_imem_we = 1'b1;
        o_busy    = 1'b1;
        w_state_next = (r_word_count + 8'd1 == r_count) ? w_end_state : S_HI;
      end
      S_CHK: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (i_byte_valid) w_state_next = (i_byte_in == r_csum) ? S_DONE : S_ERR;
`else
        w_state_next = S_ERR;
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count      <= '0;
      r_word_count <= '0;
      r_addr       <= '0;
      r_opcode     <= '0;
      r_operand    <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_word_count <= '0;
            r_addr       <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
          end
        end
        S_COUNT: begin
          if (i_byte_valid) begin
            r_count <= i_byte_in;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ i_byte_in;
`endif
          end
        end
        S_HI: begin
          if (i_byte_valid) begin
            r_opcode <= i_byte_in[IWIDTH-1:0];
`ifdef LOADER_CHECKSUM_EN
            r_csum   <= r_csum ^ i_byte_in;
`endif
          end
        end
        S_LO: begin
          if (i_byte_valid) begin
            r_operand <= i_byte_in[WIDTH-IWIDTH-1:0];
`ifdef LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ i_byte_in;
`endif
          end
        end
        S_WR: begin
          r_addr       <= r_addr + 1'b1;
          r_word_count <= r_word_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_imem_addr  = r_addr;
  assign o_imem_data  = {r_opcode, r_operand};
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; define LOADER_CHECKSUM_EN to exercise the checksum frames.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte_in = 8'd0;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic [7:0]  o_imem_addr;
  logic [12:0] o_imem_data;
  logic        o_imem_we;
  logic        o_cpu_hold;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [7:0]  o_word_count;

  int n_checks = 0;
  int n_errors = 0;
  int wr_n = 0;
  int ready_in_wr = 0;
  logic [7:0]  wr_addr [0:63];
  logic [12:0] wr_data [0:63];

  prog_loader dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_byte_in(i_byte_in),
    .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data), .o_imem_we(o_imem_we),
    .o_cpu_hold(o_cpu_hold), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_word_count(o_word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_imem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = o_imem_addr;
        wr_data[wr_n] = o_imem_data;
      end
      wr_n++;
      if (o_byte_ready) ready_in_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Presents one byte after an optional idle gap and returns 1 time unit after it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    i_byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    i_byte_in    = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: byte %0h never accepted (ready=%0b, required 1)", b, o_byte_ready);
    end
    tick();
    i_byte_valid = 1'b0;
    $display("sent byte %02h", b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, o_byte_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, o_imem_we},    32'd0);
    check({tag, "_addr"},  {24'd0, o_imem_addr},  32'd0);
    check({tag, "_data"},  {19'd0, o_imem_data},  32'd0);
    check({tag, "_hold"},  {31'd0, o_cpu_hold},   32'd0);
    check({tag, "_busy"},  {31'd0, o_busy},       32'd0);
    check({tag, "_done"},  {31'd0, o_done},       32'd0);
    check({tag, "_err"},   {31'd0, o_err},        32'd0);
    check({tag, "_wc"},    {24'd0, o_word_count}, 32'd0);
  endtask

  initial begin
    int base;
    tick(); tick();
    check_reset_outputs("rst");
    i_rst = 1'b0;
    tick();

    // START enters COUNT on the next cycle with the CPU held.
    pulse_start();
    check("start_ready", {31'd0, o_byte_ready}, 32'd1);
    check("start_hold",  {31'd0, o_cpu_hold},   32'd1);
    check("start_busy",  {31'd0, o_busy},       32'd1);

`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h01, 0); send_byte(8'h0A, 0); send_byte(8'h05, 0);
    check("ck_wr_data", {19'd0, o_imem_data}, 32'h0A05);
    send_byte(8'h0E, 0);
    check("ck_good_done", {31'd0, o_done}, 32'd1);
    check("ck_good_hold", {31'd0, o_cpu_hold}, 32'd0);
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h0A, 0); send_byte(8'h05, 0);
    send_byte(8'h0F, 0);
    check("ck_bad_err",  {31'd0, o_err},      32'd1);
    check("ck_bad_hold", {31'd0, o_cpu_hold}, 32'd1);
    check("ck_bad_done", {31'd0, o_done},     32'd0);
    check("ck_writes",   wr_n,                32'd2);
`else
    // Back-to-back two-word frame.
    send_byte(8'h02, 0); send_byte(8'h0A, 0); send_byte(8'h05, 0);
    check("w0_we",    {31'd0, o_imem_we},    32'd1);
    check("w0_ready", {31'd0, o_byte_ready}, 32'd0);
    check("w0_addr",  {24'd0, o_imem_addr},  32'd0);
    check("w0_data",  {19'd0, o_imem_data},  32'h0A05);
    send_byte(8'h02, 0); send_byte(8'h33, 0);
    check("w1_addr",  {24'd0, o_imem_addr},  32'd1);
    check("w1_data",  {19'd0, o_imem_data},  32'h0233);
    tick();
    check("f1_done", {31'd0, o_done},       32'd1);
    check("f1_hold", {31'd0, o_cpu_hold},   32'd0);
    check("f1_busy", {31'd0, o_busy},       32'd0);
    check("f1_wc",   {24'd0, o_word_count}, 32'd2);
    check("f1_nwr",  wr_n,                  32'd2);

    // Bad HI byte aborts with the CPU still held.
    pulse_start();
    check("e_done_cleared", {31'd0, o_done}, 32'd0);
    send_byte(8'h01, 0); send_byte(8'h25, 0);
    check("e_err",   {31'd0, o_err},        32'd1);
    check("e_hold",  {31'd0, o_cpu_hold},   32'd1);
    check("e_ready", {31'd0, o_byte_ready}, 32'd0);
    tick(); tick();
    check("e_nwr",   wr_n,                  32'd2);
    pulse_start();
    check("e_restart_err",   {31'd0, o_err},        32'd0);
    check("e_restart_ready", {31'd0, o_byte_ready}, 32'd1);

    // Empty frame completes right after the count byte.
    send_byte(8'h00, 0);
    check("z_done", {31'd0, o_done},       32'd1);
    check("z_wc",   {24'd0, o_word_count}, 32'd0);
    check("z_nwr",  wr_n,                  32'd2);

    // Same kind of frame with random valid gaps.
    pulse_start();
    send_byte(8'h03, $urandom_range(0, 3));
    send_byte(8'h01, $urandom_range(0, 3)); send_byte(8'h02, $urandom_range(0, 3));
    send_byte(8'h1F, $urandom_range(0, 3)); send_byte(8'hFF, $urandom_range(0, 3));
    send_byte(8'h00, $urandom_range(0, 3)); send_byte(8'h80, $urandom_range(0, 3));
    tick();
    check("g_done",  {31'd0, o_done},       32'd1);
    check("g_wc",    {24'd0, o_word_count}, 32'd3);
    check("g_nwr",   wr_n,                  32'd5);
    check("g_a0",    {24'd0, wr_addr[2]},   32'd0);
    check("g_d0",    {19'd0, wr_data[2]},   32'h0102);
    check("g_a1",    {24'd0, wr_addr[3]},   32'd1);
    check("g_d1",    {19'd0, wr_data[3]},   32'h1FFF);
    check("g_a2",    {24'd0, wr_addr[4]},   32'd2);
    check("g_d2",    {19'd0, wr_data[4]},   32'h0080);
    check("f1_a0",   {24'd0, wr_addr[0]},   32'd0);
    check("f1_d1",   {19'd0, wr_data[1]},   32'h0233);

    // Reset while waiting for a LO byte after one word.
    pulse_start();
    base = wr_n;
    send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h03, 0);
    check("r_in_lo_ready", {31'd0, o_byte_ready}, 32'd1);
    i_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(); tick(); tick();
    check("r_nwr",  wr_n - base,              32'd1);
    check("r_addr", {24'd0, wr_addr[base]},   32'd0);
    check("r_data", {19'd0, wr_data[base]},   32'h1122);
    i_rst = 1'b0;
    tick();
`endif

    check("ready_in_wr", ready_in_wr, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the one-cycle CPU. Accepts a byte stream over a valid/ready handshake, packs byte pairs into WIDTH-bit instruction words (5-bit opcode + 8-bit operand), and writes them sequentially into instruction memory from address 0. While a load is in progress it holds the CPU in reset, and it releases the CPU once the last word is written. It sits between the host byte link and the instruction memory write port, and produces the words that the instruction decoder later consumes.

## Interface
- WIDTH, 13, instruction word width
- IWIDTH, 5, opcode field width; operand width is WIDTH-IWIDTH = 8
- ADDR_WIDTH, 8, instruction memory address width

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  begin a load; sampled in IDLE, DONE and ERR only
- BYTE_IN  in  8  stream byte
- BYTE_VALID  in  1  BYTE_IN valid
- BYTE_READY  out  1  loader can accept a byte this cycle
- IMEM_ADDR  out  ADDR_WIDTH  write address
- IMEM_DATA  out  WIDTH  write data, {opcode[4:0], operand[7:0]}
- IMEM_WE  out  1  one-cycle write strobe
- CPU_HOLD  out  1  hold the CPU PC in reset
- BUSY  out  1  load in progress
- DONE  out  1  last load completed successfully (level)
- ERR  out  1  last load aborted (level)
- WORD_COUNT  out  8  words written in the current or last load

## Operation
- Transfer: a byte is accepted on a rising edge with BYTE_VALID && BYTE_READY. BYTE_READY is high only in COUNT, HI, LO and CHK.
- Frame: count byte N, then N pairs (HI, LO), then the checksum byte if CHECKSUM is enabled.
- States:
  - IDLE: START -> COUNT.
  - COUNT: on accept, latch N. If N=0, go to DONE (or CHK if checksum is enabled). If N > 2^ADDR_WIDTH, go to ERR. Otherwise go to HI.
  - HI: on accept, check BYTE_IN[7:5]. Nonzero -> ERR; otherwise latch opcode = BYTE_IN[4:0] and go to LO.
  - LO: on accept, latch operand and go to WR.
  - WR: IMEM_WE=1 for one cycle, IMEM_ADDR = current address, IMEM_DATA = {opcode, operand}. Then increment address and WORD_COUNT. If WORD_COUNT is now N, go to DONE/CHK; otherwise go to HI.
  - CHK: on accept, compare the byte with the running XOR. Match -> DONE; mismatch -> ERR.
  - DONE / ERR: hold state until START. START clears address, WORD_COUNT, checksum, DONE and ERR, then goes to COUNT.
- Outputs by state:
  - CPU_HOLD = 1 in every state except IDLE and DONE. ERR keeps the CPU held.
  - BUSY = 1 in COUNT, HI, LO, WR, CHK.
- Address: starts at 0 and is never wrapped, because N is bounded in COUNT. With ADDR_WIDTH=8, N=255 writes addresses 0..254.
- Operand: written unmodified. Opcode values are not validated beyond bits [7:5].
- Reset mid-load: everything returns to reset values immediately. Words already written stay in memory, and no further write occurs.

## Timing
- Reset values:
  - state IDLE
  - BYTE_READY=0, IMEM_WE=0, IMEM_ADDR=0, IMEM_DATA=0
  - CPU_HOLD=0, BUSY=0, DONE=0, ERR=0, WORD_COUNT=0
- All outputs are registered or decoded from the state register only. There is no combinational path from BYTE_VALID to BYTE_READY.
- START accepted at edge k -> BYTE_READY=1 and CPU_HOLD=1 from cycle k+1.
- LO byte accepted at edge k -> IMEM_WE=1 during cycle k+1, with BYTE_READY=0 in that cycle.
- Throughput: minimum 3 cycles per word.
- Last write cycle at k -> DONE=1 and CPU_HOLD=0 from cycle k+1 (checksum disabled).
- A stalled BYTE_VALID simply waits in the current state. There is no timeout.
- START while BUSY is ignored.

## Configuration
- LOADER_CHECKSUM_EN:
  - Defined: CHK state present. The running XOR covers the count byte and all HI/LO bytes; the trailing byte must equal it.
  - Undefined: no CHK state; the frame ends after the last LO byte.

## Test plan
- Checksum off, START, bytes 02, 0A, 05, 02, 33 -> two writes: addr 0 data 0x0A05, addr 1 data 0x0233. DONE=1, CPU_HOLD=0, WORD_COUNT=2.
- HI byte 0x25 -> ERR=1, CPU_HOLD=1, no IMEM_WE. A following START clears ERR and re-enters COUNT.
- N=0 -> DONE on the cycle after the count byte is accepted, with no writes.
- BYTE_VALID toggled randomly during the frame -> same writes as the back-to-back case; BYTE_READY=0 in every WR cycle.
- RST asserted in LO after one word is written -> all outputs return to reset values at once; memory keeps addr 0 only.
- LOADER_CHECKSUM_EN defined, frame 01, 0A, 05, checksum 0E -> DONE. Same frame with checksum 0F -> ERR, CPU_HOLD=1.
